tlb_op_ctrl: RTL
================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences TLBP/TLBR/TLBWI/TLBWR from the M stage into the shared TLB array: stalls the pipe,
//  issues a one-cycle strobe, writes results back to CP0, and forces a refetch after TLB writes.
//  Owns the CP0 Random and Wired registers. Sits between M-stage decode/CP0 and the tlb block.
// PARAMETERS
//  TLB_LINE_NUM       8   number of TLB entries (power of 2)
//  LOG2_TLB_LINE_NUM  3   index width
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-low reset (rst==0 resets)
//  tlbp_m         in   1   M-stage instr is TLBP (qualified: valid, no exception)
//  tlbr_m         in   1   M-stage instr is TLBR
//  tlbwi_m        in   1   M-stage instr is TLBWI
//  tlbwr_m        in   1   M-stage instr is TLBWR
//  pc_m           in   32  PC of M-stage instr
//  flush_m        in   1   M stage flushed this cycle
//  wired_we       in   1   MTC0 to Wired
//  wired_wdata    in   32  MTC0 data (low LOG2 bits used)
//  tlbp_o/tlbr_o/tlbwi_o/tlbwr_o out 1 each  one-cycle strobes to TLB
//  random_o       out  32  CP0 Random (to TLB Random_in and MFC0)
//  wired_o        out  32  CP0 Wired
//  cp0_index_we   out  1   latch TLB Index_out into CP0 Index (TLBP result)
//  cp0_tlbr_we    out  1   latch TLB EntryHi/PageMask/EntryLo0/1 outputs into CP0 (TLBR result)
//  stall_req      out  1   hold F..M stages
//  refetch_req    out  1   flush F..M, redirect fetch
//  refetch_pc     out  32  redirect target
// BEHAVIOUR
//  Reset: state IDLE, Random=TLB_LINE_NUM-1, Wired=0, all strobes/we/stall/refetch=0, refetch_pc=0.
//  Op select (priority if >1 flag set): TLBWI > TLBWR > TLBR > TLBP; others ignored.
//  FSM:
//   IDLE : op present & ~flush_m -> stall_req=1 (combinational), latch op, pc_m+4; -> ISSUE.
//          flush_m has priority: op dropped, stay IDLE, no stall.
//   ISSUE: exactly one strobe high; stall_req=1; for TLBWR random_o frozen at snapshot. -> WB.
//          flush_m ignored from ISSUE onward (op commits).
//   WB   : TLBP: cp0_index_we=1; TLBR: cp0_tlbr_we=1; writes: no we. stall_req=1.
//          TLBP/TLBR -> IDLE (stall drops next cycle). TLBWI/TLBWR -> REFETCH.
//   REFETCH: refetch_req=1 one cycle, refetch_pc=latched pc_m+4, stall_req=0. -> IDLE.
//  Latency: op accepted at t; strobe at t+1; CP0 writeback at t+2; refetch at t+3 (writes).
//  Stall: TLBP/TLBR 3 cycles (t..t+2); writes 3 cycles + refetch pulse.
//  Random: each cycle not frozen, if Random==Wired -> TLB_LINE_NUM-1 else Random-1.
//   Wired>=TLB_LINE_NUM-1 -> Random held at TLB_LINE_NUM-1.
//   wired_we: Wired<=wdata[LOG2-1:0] zero-extended, Random<=TLB_LINE_NUM-1 same edge
//   (overrides decrement; if in ISSUE of TLBWR, the snapshot already used is unaffected).
//  random_o/wired_o upper bits are zero. pc_m+4 is modulo 2^32.
//  Reset asserted mid-op: aborts immediately, no strobe/we/refetch emitted afterwards.
// STRUCTURE
//  Shared package/defines: FSM state encodings (IDLE/ISSUE/WB/REFETCH, 2 bits), op encoding
//  (NONE/TLBP/TLBR/TLBWI/TLBWR), TLB_LINE_NUM/LOG2 reused from existing TLB defines.
//  Sub-module: tlb_random_ctr (Random/Wired registers, freeze input, wired write port).
// TESTING
//  Reset: rst=0 2 cycles -> random_o=7, wired_o=0, all outputs 0; then Random 7,6,..,0,7 wraps.
//  wired_we=1, wdata=3 at Random=5 -> next Random=7, sequence 7,6,5,4,3,7.
//  tlbp_m at t, pc_m=0x8000_1000 -> stall t..t+2, tlbp_o @t+1, cp0_index_we @t+2, no refetch.
//  tlbwr_m with Random=4 at ISSUE -> tlbwr_o @t+1 with random_o=4 held, refetch_req @t+3,
//   refetch_pc=0x8000_1004.
//  tlbwi_m and tlbp_m both set -> only tlbwi_o pulses; flush_m with tlbr_m in IDLE -> no activity.
//  rst=0 during WB of TLBR -> cp0_tlbr_we stays 0, state IDLE, Random=7 next cycle.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// tlb_op_ctrl_pkg: shared TLB sizing, FSM state and op encodings, op priority select
package tlb_op_ctrl_pkg;
   localparam int TLB_LINE_NUM      = 8;
   localparam int LOG2_TLB_LINE_NUM = 3;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WB, ST_REFETCH} state_e;
   typedef enum logic [2:0] {OP_NONE, OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR} op_e;
   function automatic op_e op_sel(input logic p, input logic r, input logic wi, input logic wr);
      return wi ? OP_TLBWI : wr ? OP_TLBWR : r ? OP_TLBR : p ? OP_TLBP : OP_NONE;
   endfunction
endpackage

// File: rtl/tlb_random_ctr.sv
// tlb_random_ctr: CP0 Random/Wired registers with freeze and Wired write port
module tlb_random_ctr
   import tlb_op_ctrl_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         freeze_i,
   input  logic                         wired_we_i,
   input  logic [LOG2_TLB_LINE_NUM-1:0] wired_wdata_i,
   output logic [LOG2_TLB_LINE_NUM-1:0] random_o,
   output logic [LOG2_TLB_LINE_NUM-1:0] wired_o
);
   localparam int LW = LOG2_TLB_LINE_NUM;
   localparam logic [LW-1:0] MAX = LW'(TLB_LINE_NUM - 1);
   logic [LW-1:0] random_q, random_d, wired_q, wired_d;
   always_comb begin
      wired_d  = wired_we_i ? wired_wdata_i : wired_q;
      random_d = wired_we_i ? MAX :
                 freeze_i ? random_q :
                 (wired_q >= MAX || random_q == wired_q) ? MAX : random_q - LW'(1);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         random_q <= MAX;
         wired_q  <= '0;
      end else begin
         random_q <= random_d;
         wired_q  <= wired_d;
      end
   end
   assign random_o = random_q;
   assign wired_o  = wired_q;
endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences M-stage TLB ops into the TLB array with stall, strobe, CP0 writeback and refetch
module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tlbp_m,
   input  logic        tlbr_m,
   input  logic        tlbwi_m,
   input  logic        tlbwr_m,
   input  logic [31:0] pc_m,
   input  logic        flush_m,
   input  logic        wired_we,
   input  logic [31:0] wired_wdata,
   output logic        tlbp_o,
   output logic        tlbr_o,
   output logic        tlbwi_o,
   output logic        tlbwr_o,
   output logic [31:0] random_o,
   output logic [31:0] wired_o,
   output logic        cp0_index_we,
   output logic        cp0_tlbr_we,
   output logic        stall_req,
   output logic        refetch_req,
   output logic [31:0] refetch_pc
);
   localparam int LW = LOG2_TLB_LINE_NUM;
   state_e state_q, state_d;
   op_e op_q, op_d, sel;
   logic [31:0] pc_q, pc_d;
   logic [LW-1:0] rnd, wrd;
   logic unused_wdata;
   assign unused_wdata = ^wired_wdata[31:LW];
   assign sel = op_sel(tlbp_m, tlbr_m, tlbwi_m, tlbwr_m);
   // Outputs are gated by rst so a mid-op reset silences the current cycle too.
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      pc_d = pc_q;
      {tlbp_o, tlbr_o, tlbwi_o, tlbwr_o} = '0;
      cp0_index_we = 1'b0;
      cp0_tlbr_we = 1'b0;
      stall_req = 1'b0;
      refetch_req = 1'b0;
      if (rst) begin
         case (state_q)
            ST_IDLE: if (sel != OP_NONE && !flush_m) begin
               stall_req = 1'b1;
               op_d = sel;
               pc_d = pc_m + 32'd4;
               state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               stall_req = 1'b1;
               tlbp_o = op_q == OP_TLBP;
               tlbr_o = op_q == OP_TLBR;
               tlbwi_o = op_q == OP_TLBWI;
               tlbwr_o = op_q == OP_TLBWR;
               state_d = ST_WB;
            end
            ST_WB: begin
               stall_req = 1'b1;
               cp0_index_we = op_q == OP_TLBP;
               cp0_tlbr_we = op_q == OP_TLBR;
               state_d = (op_q == OP_TLBWI || op_q == OP_TLBWR) ? ST_REFETCH : ST_IDLE;
            end
            default: begin
               refetch_req = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q <= OP_NONE;
         pc_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         pc_q <= pc_d;
      end
   end
   tlb_random_ctr u_rnd (
      .clk(clk),
      .rst(rst),
      .freeze_i(state_q == ST_ISSUE && op_q == OP_TLBWR),
      .wired_we_i(wired_we),
      .wired_wdata_i(wired_wdata[LW-1:0]),
      .random_o(rnd),
      .wired_o(wrd)
   );
   assign random_o = 32'(rnd);
   assign wired_o = 32'(wrd);
   assign refetch_pc = pc_q;
endmodule
